// File: rtl/ean13_scan_scheduler.sv
// Frame/line scan scheduler for an EAN-13 scanner: gates scanning to selected
// lines, confirms codes over consecutive lines and suppresses quick repeats.
module ean13_scan_scheduler #(
  parameter int V_ACTIVE        = 16,
  parameter int LINE_STRIDE     = 2,
  parameter int CONFIRM_COUNT   = 3,
  parameter int SUPPRESS_FRAMES = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iFrameStart,
  input  logic        iLineStart,
  input  logic        iNewData,
  input  logic [51:0] iDataCode,
  input  logic        iCodeReady,
  output logic        oScanEnable,
  output logic [51:0] oCode,
  output logic        oCodeValid,
  output logic        oLocked
);

  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam logic [LW-1:0] VMAX = LW'(V_ACTIVE);
  localparam logic [3:0]    CC   = 4'(CONFIRM_COUNT);
  localparam logic [3:0]    SF   = 4'(SUPPRESS_FRAMES);

  localparam logic [2:0] S_IDLE   = 3'b001;
  localparam logic [2:0] S_SCAN   = 3'b010;
  localparam logic [2:0] S_REPORT = 3'b100;

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic          en_q, en_d;
  logic          got_q, got_d;
  logic [3:0]    match_q, match_d;
  logic [51:0]   cand_q, cand_d;
  logic [51:0]   last_q, last_d;
  logic [51:0]   code_q, code_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          supp_q, supp_d;
  logic [3:0]    scnt_q, scnt_d;

  logic       in_scan, accept, reached, supp_hit, confirm, xfer, miss;
  logic [3:0] acc_match;

  assign in_scan = (state_q == S_SCAN);
  assign accept  = in_scan & en_q & ~got_q & iNewData;
  assign xfer    = (state_q == S_REPORT) & valid_q & iCodeReady;
  assign miss    = in_scan & en_q & ~got_q & iLineStart & ~accept;

  always_comb begin
    acc_match = 4'd1;
    if ((iDataCode == cand_q) && (match_q != 4'd0)) begin
      acc_match = (match_q == CC) ? match_q : match_q + 4'd1;
    end
  end

  // After an accept the candidate is always iDataCode, so compare it directly.
  assign reached  = accept & ~iFrameStart & (acc_match == CC);
  assign supp_hit = reached & supp_q & (iDataCode == last_q);
  assign confirm  = reached & ~supp_hit;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (iFrameStart) state_d = S_SCAN;
      S_SCAN:   if (confirm)     state_d = S_REPORT;
      S_REPORT: if (xfer)        state_d = S_SCAN;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    line_d   = line_q;
    got_d    = got_q;
    match_d  = match_q;
    cand_d   = cand_q;
    last_d   = last_q;
    code_d   = code_q;
    valid_d  = valid_q;
    supp_d   = supp_q;
    scnt_d   = scnt_q;

    if (iFrameStart) begin
      line_d = '0;
    end else if (iLineStart && (line_q != VMAX)) begin
      line_d = line_q + 1'b1;
    end
    en_d = (state_d == S_SCAN) && (line_d != VMAX) &&
           ((32'(line_d) % 32'(LINE_STRIDE)) == 32'd0);

    if (iFrameStart || iLineStart) begin
      got_d = 1'b0;
    end else if (accept) begin
      got_d = 1'b1;
    end

    if (accept) begin
      match_d = acc_match;
      cand_d  = iDataCode;
    end else if (miss) begin
      match_d = 4'd0;
    end
    if (supp_hit || (in_scan && iFrameStart) || xfer) begin
      match_d = 4'd0;
    end

    if (confirm) begin
      code_d  = iDataCode;
      valid_d = 1'b1;
    end

    if (xfer) begin
      last_d  = code_q;
      valid_d = 1'b0;
      supp_d  = 1'b1;
      scnt_d  = 4'd0;
    end else if (supp_hit) begin
      scnt_d = 4'd0;
    end else if (iFrameStart && supp_q) begin
      if (scnt_q + 4'd1 == SF) begin
        supp_d = 1'b0;
        scnt_d = 4'd0;
      end else begin
        scnt_d = scnt_q + 4'd1;
      end
    end

    locked_d = (match_d != 4'd0);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      line_q   <= '0;
      en_q     <= 1'b0;
      got_q    <= 1'b0;
      match_q  <= 4'd0;
      cand_q   <= '0;
      last_q   <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      supp_q   <= 1'b0;
      scnt_q   <= 4'd0;
    end else begin
      line_q   <= line_d;
      en_q     <= en_d;
      got_q    <= got_d;
      match_q  <= match_d;
      cand_q   <= cand_d;
      last_q   <= last_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      supp_q   <= supp_d;
      scnt_q   <= scnt_d;
    end
  end

  assign oScanEnable = en_q;
  assign oCode       = code_q;
  assign oCodeValid  = valid_q;
  assign oLocked     = locked_q;

endmodule

// File: tb/tb_ean13_scan_scheduler.sv
// Scoreboard bench: an event-level model predicts confirmed codes, a monitor
// pops them on each accepted transfer and watches REPORT stability.
module tb_ean13_scan_scheduler;
  localparam int V  = 16;
  localparam int S  = 2;
  localparam int CC = 3;
  localparam int SF = 4;

  logic        iClk = 0, iRst = 0, iFrameStart = 0, iLineStart = 0, iNewData = 0;
  logic [51:0] iDataCode = '0;
  logic        iCodeReady = 0;
  logic        oScanEnable, oCodeValid, oLocked;
  logic [51:0] oCode;

  ean13_scan_scheduler #(.V_ACTIVE(V), .LINE_STRIDE(S), .CONFIRM_COUNT(CC),
                         .SUPPRESS_FRAMES(SF)) dut (
    .iClk(iClk), .iRst(iRst), .iFrameStart(iFrameStart), .iLineStart(iLineStart),
    .iNewData(iNewData), .iDataCode(iDataCode), .iCodeReady(iCodeReady),
    .oScanEnable(oScanEnable), .oCode(oCode), .oCodeValid(oCodeValid), .oLocked(oLocked));

  always #5 iClk = ~iClk;

  int n_cmp = 0, n_err = 0;
  logic [51:0] exp_q[$];

  localparam logic [51:0] A = 52'hA_BCDE_F012_3456;
  localparam logic [51:0] B = 52'h5_5555_AAAA_5555;
  localparam logic [51:0] C = 52'hA_BCDE_F012_3457;   // A with bit 0 flipped
  localparam logic [51:0] D = 52'h2_BCDE_F012_3456;   // A with bit 51 flipped

  // Event-level reference state
  logic [51:0] m_cand, m_last;
  int m_match, m_scnt, m_line;
  bit m_supp, m_got, m_started;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic bit m_en();
    return m_started && (m_line < V) && (m_line % S == 0);
  endfunction

  task automatic m_clear();
    m_cand = '0; m_last = '0; m_match = 0; m_scnt = 0; m_line = 0;
    m_supp = 0; m_got = 0; m_started = 0;
  endtask

  task automatic do_reset();
    iRst = 1; tick(); iRst = 0;
    m_clear();
    exp_q.delete();
    check("rst_en", oScanEnable, 0);
    check("rst_valid", oCodeValid, 0);
    check("rst_code", oCode, 0);
    check("rst_locked", oLocked, 0);
  endtask

  task automatic frame(input bit with_line);
    iFrameStart = 1; iLineStart = with_line; tick();
    iFrameStart = 0; iLineStart = 0;
    if (m_supp) begin
      m_scnt++;
      if (m_scnt == SF) begin m_supp = 0; m_scnt = 0; end
    end
    m_match = 0; m_line = 0; m_got = 0; m_started = 1;
    $display("frame (coincident line=%0d) en=%0d", with_line, oScanEnable);
    check("frame_en", oScanEnable, m_en());
    check("frame_locked", oLocked, 0);
  endtask

  task automatic line_end();
    iLineStart = 1; tick(); iLineStart = 0;
    if (m_en() && !m_got) m_match = 0;
    if (m_line < V) m_line++;
    m_got = 0;
    check("line_en", oScanEnable, m_en());
    check("line_locked", oLocked, m_match != 0);
  endtask

  task automatic drain(input logic [51:0] code, input int hold);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      iCodeReady = (k >= hold) && ($urandom_range(0, 3) == 0);
      if (!iCodeReady && $urandom_range(0, 1) == 1) begin
        iNewData = 1; iDataCode = {$urandom, $urandom};
      end
      if (iCodeReady && oCodeValid) done = 1;
      tick();
      iNewData = 0;
      if (!done) check("report_en", oScanEnable, 0);
    end
    iCodeReady = 0;
    check("drain_done", done, 1);
    check("post_xfer_valid", oCodeValid, 0);
    m_last = code; m_supp = 1; m_scnt = 0; m_match = 0;
    check("post_xfer_en", oScanEnable, m_en());
    check("post_xfer_locked", oLocked, 0);
  endtask

  task automatic data(input logic [51:0] code, input bit dup, input int hold, input bit do_drain);
    bit conf = 0;
    iNewData = 1; iDataCode = code; tick(); iNewData = 0;
    if (m_en() && !m_got) begin
      m_got = 1;
      if (code == m_cand && m_match > 0) begin
        if (m_match < CC) m_match++;
      end else begin
        m_cand = code; m_match = 1;
      end
      if (m_match == CC) begin
        if (m_supp && code == m_last) begin m_scnt = 0; m_match = 0; end
        else conf = 1;
      end
    end
    $display("data code=%h conf=%0d valid=%0d", code, conf, oCodeValid);
    check("data_valid", oCodeValid, conf);
    check("data_locked", oLocked, m_match != 0);
    if (conf) begin
      exp_q.push_back(code);
      if (do_drain) drain(code, hold);
    end else if (dup) begin
      iNewData = 1; iDataCode = (code == A) ? B : A; tick(); iNewData = 0;
      check("dup_valid", oCodeValid, 0);
      check("dup_locked", oLocked, m_match != 0);
    end
  endtask

  // Frame whose enabled lines (even lines) carry code c, skipping slot miss_at
  task automatic run_frame(input logic [51:0] c, input int nres, input int miss_at);
    frame(0);
    for (int i = 0; i < 2 * nres; i++) begin
      if (i % 2 == 0 && i / 2 != miss_at) data(c, 0, 0, 1);
      line_end();
    end
  endtask

  // Monitor: pops on transfer, checks REPORT stability under backpressure
  logic prev_v = 0, prev_r = 0, prev_rst = 1;
  logic [51:0] prev_code = '0;
  always @(negedge iClk) begin
    if (!prev_rst && prev_v && !prev_r) begin
      check("hold_valid", oCodeValid, 1);
      check("hold_code", oCode, prev_code);
    end
    if (!iRst && oCodeValid && iCodeReady) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_xfer: got %h expected none", oCode);
      end else begin
        logic [51:0] e;
        e = exp_q.pop_front();
        $display("xfer code=%h", oCode);
        check("xfer_code", oCode, e);
      end
    end
    prev_v = oCodeValid; prev_r = iCodeReady; prev_code = oCode; prev_rst = iRst;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [51:0] pool [4];
    pool[0] = A; pool[1] = B; pool[2] = C; pool[3] = D;
    m_clear();
    tick();
    do_reset();

    // Basic confirm with 20-cycle backpressure, then remaining lines
    frame(0);
    data(A, 0, 0, 1); line_end(); line_end();
    data(A, 0, 0, 1); line_end(); line_end();
    data(A, 0, 20, 1); line_end(); line_end();

    // Miss breaks the run; then a mismatch restarts it
    do_reset();
    run_frame(A, 6, 2);
    do_reset();
    frame(0);
    data(A, 0, 0, 1); line_end(); line_end();
    for (int i = 0; i < 3; i++) begin data(B, 0, 0, 1); line_end(); line_end(); end

    // Suppression window, then expiry
    do_reset();
    run_frame(A, 3, 99);
    run_frame(A, 3, 99);
    for (int f = 0; f < 3; f++) run_frame(A, 3, 0);
    run_frame(A, 3, 99);

    // Duplicate pulses and coincident frame/line start
    do_reset();
    frame(1);
    data(A, 1, 0, 1); line_end(); line_end();
    data(A, 1, 0, 1); line_end(); line_end();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int nl;
      frame($urandom_range(0, 9) == 0);
      nl = $urandom_range(4, 20);
      for (int l = 0; l < nl; l++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 9) < 7)
          data(($urandom_range(0, 9) < 6) ? A : pool[$urandom_range(1, 3)],
               $urandom_range(0, 4) == 0, $urandom_range(0, 5), 1);
        line_end();
      end
    end

    // Reset while a code is pending
    do_reset();
    frame(0);
    data(B, 0, 0, 1); line_end(); line_end();
    data(B, 0, 0, 1); line_end(); line_end();
    data(B, 0, 0, 0);
    check("pending_valid", oCodeValid, 1);
    do_reset();
    line_end();
    data(B, 0, 0, 1);
    line_end(); line_end();
    check("idle_en", oScanEnable, 0);
    frame(0);
    check("restart_en", oScanEnable, 1);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
